// File: rtl/hh_membrane_update.sv
// Hodgkin-Huxley membrane integrator: one Euler step of V per accepted gate
// sample, computed over ten cycles through a single shared multiplier.
module hh_membrane_update #(
  parameter int G_NA   = 1200,
  parameter int G_K    = 360,
  parameter int G_L    = 3,
  parameter int E_NA   = 5000,
  parameter int E_K    = -7700,
  parameter int E_L    = -5440,
  parameter int V_INIT = -6500
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] m_in,
  input  logic signed [15:0] h_in,
  input  logic signed [15:0] n_in,
  input  logic signed [15:0] i_ext,
  input  logic        [15:0] dt,
  output logic signed [15:0] v_out,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned GW = 16;
  localparam int unsigned AW = 48;

  localparam logic signed [AW-1:0] K10    = AW'(10);
  localparam logic signed [AW-1:0] K1000  = AW'(1000);
  localparam logic signed [AW-1:0] K10000 = AW'(10000);
  localparam logic signed [AW-1:0] GNA_W  = AW'(G_NA);
  localparam logic signed [AW-1:0] GK_W   = AW'(G_K);
  localparam logic signed [AW-1:0] GL_W   = AW'(G_L);
  localparam logic signed [AW-1:0] ENA_W  = AW'(E_NA);
  localparam logic signed [AW-1:0] EK_W   = AW'(E_K);
  localparam logic signed [AW-1:0] EL_W   = AW'(E_L);
  localparam logic signed [AW-1:0] VMAX_W = AW'(32767);
  localparam logic signed [AW-1:0] VMIN_W = AW'(-32768);

  typedef enum logic [3:0] {
    IDLE, M2, M3, M3H, INA, N2, N3, N4, IK, IL, UPD, DONE
  } state_e;

  state_e state_q, state_d;

  logic signed [GW-1:0] m_q, m_d, h_q, h_d, n_q, n_d, iext_q, iext_d;
  logic        [GW-1:0] dt_q, dt_d;
  logic signed [GW-1:0] v_q, v_d;
  logic signed [AW-1:0] t_q, t_d, g_q, g_d;
  logic signed [AW-1:0] ina_q, ina_d, ik_q, ik_d, il_q, il_d;

  logic signed [AW-1:0] mul_a, mul_b, mul_p;
  logic signed [AW-1:0] i_sum, v_sum;

  // Gates are fractions of 1000; out-of-range samples are pinned to [0, 1000]
  function automatic logic signed [GW-1:0] clamp_gate(input logic signed [GW-1:0] x);
    if (x < 0)              return GW'(0);
    else if (x > GW'(1000)) return GW'(1000);
    else                    return x;
  endfunction

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign v_out     = v_q;

  assign i_sum = AW'(iext_q) - ina_q - ik_q - il_q;
  assign mul_p = mul_a * mul_b;
  assign v_sum = AW'(v_q) + mul_p / K1000;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: fixed compute chain, handshakes only at IDLE and DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = M2;
      M2:      state_d = M3;
      M3:      state_d = M3H;
      M3H:     state_d = INA;
      INA:     state_d = N2;
      N2:      state_d = N3;
      N3:      state_d = N4;
      N4:      state_d = IK;
      IK:      state_d = IL;
      IL:      state_d = UPD;
      UPD:     state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shared multiplier operand select; constant scalings are applied after
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      M2:      begin mul_a = AW'(m_q);  mul_b = AW'(m_q);           end
      M3:      begin mul_a = t_q;       mul_b = AW'(m_q);           end
      M3H:     begin mul_a = t_q;       mul_b = AW'(h_q);           end
      INA:     begin mul_a = g_q;       mul_b = AW'(v_q) - ENA_W;   end
      N2:      begin mul_a = AW'(n_q);  mul_b = AW'(n_q);           end
      N3, N4:  begin mul_a = t_q;       mul_b = AW'(n_q);           end
      IK:      begin mul_a = t_q;       mul_b = AW'(v_q) - EK_W;    end
      IL:      begin mul_a = GL_W;      mul_b = AW'(v_q) - EL_W;    end
      UPD:     begin mul_a = i_sum;     mul_b = AW'(dt_q);          end
      default: begin mul_a = '0;        mul_b = '0;                 end
    endcase
  end

  // Datapath next values: capture on accept, one partial result per state
  always_comb begin
    m_d    = m_q;
    h_d    = h_q;
    n_d    = n_q;
    iext_d = iext_q;
    dt_d   = dt_q;
    t_d    = t_q;
    g_d    = g_q;
    ina_d  = ina_q;
    ik_d   = ik_q;
    il_d   = il_q;
    v_d    = v_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          m_d    = clamp_gate(m_in);
          h_d    = clamp_gate(h_in);
          n_d    = clamp_gate(n_in);
          iext_d = i_ext;
          dt_d   = dt;
        end
      end
      M2, M3, N2, N3, N4: t_d = mul_p / K1000;
      M3H:  g_d   = mul_p / K1000;
      INA:  ina_d = (mul_p * GNA_W) / K10000;
      IK:   ik_d  = (mul_p * GK_W) / K10000;
      IL:   il_d  = mul_p / K10;
      UPD: begin
        if (v_sum > VMAX_W)      v_d = GW'(32767);
        else if (v_sum < VMIN_W) v_d = GW'(-32768);
        else                     v_d = GW'(v_sum);
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any step in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q    <= '0;
      h_q    <= '0;
      n_q    <= '0;
      iext_q <= '0;
      dt_q   <= '0;
      t_q    <= '0;
      g_q    <= '0;
      ina_q  <= '0;
      ik_q   <= '0;
      il_q   <= '0;
      v_q    <= GW'(V_INIT);
    end else begin
      m_q    <= m_d;
      h_q    <= h_d;
      n_q    <= n_d;
      iext_q <= iext_d;
      dt_q   <= dt_d;
      t_q    <= t_d;
      g_q    <= g_d;
      ina_q  <= ina_d;
      ik_q   <= ik_d;
      il_q   <= il_d;
      v_q    <= v_d;
    end
  end

endmodule

// File: tb/tb_hh_membrane_update.sv
// Directed bench for hh_membrane_update with hand-computed membrane values.
module tb_hh_membrane_update;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] m_in, h_in, n_in, i_ext;
  logic        [15:0] dt;
  logic signed [15:0] v_out;
  logic               out_valid;
  logic               out_ready;

  int checks = 0;
  int errors = 0;

  hh_membrane_update dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .m_in      (m_in),
    .h_in      (h_in),
    .n_in      (n_in),
    .i_ext     (i_ext),
    .dt        (dt),
    .v_out     (v_out),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply reset for two cycles, released on a falling edge
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Offer one sample, return cycles from accept edge (counted as 1) to out_valid
  task automatic run_step(input logic signed [15:0] m, input logic signed [15:0] h,
                          input logic signed [15:0] n, input logic signed [15:0] ie,
                          input logic [15:0] d, output int lat);
    int guard;
    @(negedge clk);
    m_in = m; h_in = h; n_in = n; i_ext = ie; dt = d;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (v_out !== -16'sd6500) begin errors++; $display("FAIL reset_v: got %0d exp -6500", v_out); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_resting();
    int lat;
    do_reset();
    run_step(16'sd53, 16'sd596, 16'sd318, 16'sd0, 16'd10, lat);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL rest_latency: got %0d exp 11", lat); end
    checks++;
    if (v_out !== -16'sd6501) begin errors++; $display("FAIL rest_v: got %0d exp -6501", v_out); end
    // After release, v_out must hold through IDLE
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rest_idle_ready: got %b exp 1", in_ready); end
    checks++;
    if (v_out !== -16'sd6501) begin errors++; $display("FAIL rest_idle_hold: got %0d exp -6501", v_out); end
  endtask

  task automatic test_full_gates();
    int lat;
    do_reset();
    run_step(16'sd1000, 16'sd1000, 16'sd1000, 16'sd0, 16'd10, lat);
    checks++;
    if (v_out !== 16'sd6871) begin errors++; $display("FAIL full_v: got %0d exp 6871", v_out); end
    // Gates above 1000 clamp to 1000 and give the same result
    do_reset();
    run_step(16'sd1500, 16'sd2000, 16'sd32000, 16'sd0, 16'd10, lat);
    checks++;
    if (v_out !== 16'sd6871) begin errors++; $display("FAIL clamp_high_v: got %0d exp 6871", v_out); end
  endtask

  task automatic test_saturation();
    int lat;
    do_reset();
    run_step(16'sd1000, 16'sd1000, 16'sd1000, 16'sd0, 16'd1000, lat);
    checks++;
    if (v_out !== 16'sd32767) begin errors++; $display("FAIL sat_v: got %0d exp 32767", v_out); end
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL sat_latency: got %0d exp 11", lat); end
  endtask

  task automatic test_ext_clamp();
    int lat;
    do_reset();
    run_step(16'sd0, -16'sd5, 16'sd0, 16'sd1000, 16'd100, lat);
    checks++;
    if (v_out !== -16'sd6369) begin errors++; $display("FAIL ext_v: got %0d exp -6369", v_out); end
  endtask

  task automatic test_backpressure();
    int lat;
    do_reset();
    out_ready = 1'b0;
    run_step(16'sd53, 16'sd596, 16'sd318, 16'sd0, 16'd10, lat);
    checks++;
    if (v_out !== -16'sd6501) begin errors++; $display("FAIL bp_first_v: got %0d exp -6501", v_out); end
    m_in = 16'sd1000; h_in = 16'sd1000; n_in = 16'sd1000; i_ext = 16'sd0; dt = 16'd1000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = i[0];
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || v_out !== -16'sd6501) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got valid=%b ready=%b v=%0d exp valid=1 ready=0 v=-6501",
                 i, out_valid, in_ready, v_out);
      end
    end
    // Pulse out_ready with in_valid still high: the DONE-cycle offer is not taken
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
    end
    checks++;
    if (v_out !== -16'sd6501) begin errors++; $display("FAIL bp_release_v: got %0d exp -6501", v_out); end
    out_ready = 1'b1;
    // Next step starts from V=-6501: I_L=-318, I=1318, dV=131
    run_step(16'sd0, -16'sd5, 16'sd0, 16'sd1000, 16'd100, lat);
    checks++;
    if (lat !== 11) begin errors++; $display("FAIL bp_next_latency: got %0d exp 11", lat); end
    checks++;
    if (v_out !== -16'sd6370) begin errors++; $display("FAIL bp_next_v: got %0d exp -6370", v_out); end
  endtask

  task automatic test_reset_mid();
    int lat;
    do_reset();
    @(negedge clk);
    m_in = 16'sd1000; h_in = 16'sd1000; n_in = 16'sd1000; i_ext = 16'sd0; dt = 16'd10;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (v_out !== -16'sd6500) begin errors++; $display("FAIL mid_reset_v: got %0d exp -6500", v_out); end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_flags: got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || v_out !== -16'sd6500) begin
      errors++;
      $display("FAIL mid_reset_after: got valid=%b v=%0d exp valid=0 v=-6500", out_valid, v_out);
    end
    run_step(16'sd53, 16'sd596, 16'sd318, 16'sd0, 16'd10, lat);
    checks++;
    if (v_out !== -16'sd6501) begin errors++; $display("FAIL mid_reset_rest_v: got %0d exp -6501", v_out); end
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    m_in = '0; h_in = '0; n_in = '0; i_ext = '0; dt = '0;
    test_reset();
    test_resting();
    test_full_gates();
    test_saturation();
    test_ext_clamp();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
